// File: rtl/bkpt_pkg.sv
// Shared constants for the breakpoint / single-step NMI block: register map,
// bit positions, the instruction-fetch bus-status code and step FSM states.
package bkpt_pkg;
    localparam logic [3:0] RS_CTRL = 4'd8;
    localparam logic [3:0] RS_STEP = 4'd9;
    localparam logic [3:0] RS_STAT = 4'd10;

    localparam int CTRL_STEP_EN = 8;
    localparam int CTRL_CLR     = 9;
    localparam int STAT_STEP    = 8;

    localparam logic [3:0] BST_IAQ = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_FIRE  = 2'd2
    } step_state_t;
endpackage

// File: rtl/bkpt_nmi_if.sv
// CPU-side bus bundle: address/status/strobe snoop, register-file port, NMI.
// The read-data signal is named dout because "do" is a reserved word.
interface bkpt_nmi_if;
    logic [15:0] ab;
    logic [3:0]  bst;
    logic        as;
    logic        iaq;
    logic        user;
    logic        csn;
    logic [3:0]  rs;
    logic        nwr;
    logic [15:0] di;
    logic [15:0] dout;
    logic        nmi;

    modport master (output ab, bst, as, iaq, user, csn, rs, nwr, di,
                    input  dout, nmi);
    modport slave  (input  ab, bst, as, iaq, user, csn, rs, nwr, di,
                    output dout, nmi);
endinterface

// File: rtl/bkpt_cmp.sv
// One breakpoint comparator: address register, enable bit, fetch-address match.
// hit is combinational from the current (pre-write) register values; no backpressure.
module bkpt_cmp (
    input  logic        clk_25mhz,
    input  logic        reset,
    input  logic        addr_wr,
    input  logic        en_wr,
    input  logic [15:0] wdat,
    input  logic        en_dat,
    input  logic        qual,
    input  logic [15:0] ab,
    output logic [15:0] addr,
    output logic        en,
    output logic        hit
);
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            addr <= '0;
            en   <= 1'b0;
        end else begin
            if (addr_wr) addr <= wdat;
            if (en_wr)   en   <= en_dat;
        end
    end

    assign hit = qual & en & (ab == addr);
endmodule

// File: rtl/bkpt_nmi.sv
// Breakpoint and single-step NMI generator with a small word register file.
// nmi rises one clock after the triggering fetch and drops on the next fetch edge.
module bkpt_nmi
    import bkpt_pkg::*;
#(
    parameter int          NBP       = 4,
    parameter int          CW        = 8,
    parameter int          DELAY     = 3,
    parameter logic [15:0] LREX_ADDR = 16'h1ece,
    parameter bit          USER_ONLY = 1'b1
) (
    input  logic     clk_25mhz,
    input  logic     reset,
    bkpt_nmi_if.slave bus
);
    logic           fs, lrex, we, ctrl_wr, clr, qual, nmi;
    logic [NBP-1:0] hit, bp_en, stat_hit;
    logic [15:0]    bp_addr [NBP];
    logic           step_en, stat_step, bp_pend;
    logic [CW-1:0]  step_cnt, cnt;
    step_state_t    state;

    assign fs      = bus.as & bus.iaq;
    assign lrex    = (bus.ab == LREX_ADDR) & (bus.bst == BST_IAQ);
    assign we      = ~bus.csn & ~bus.nwr;
    assign ctrl_wr = we & (bus.rs == RS_CTRL);
    assign clr     = ctrl_wr & bus.di[CTRL_CLR];
    // Suppressing hits while nmi is up keeps the handler's own fetches from re-triggering.
    assign qual    = fs & (bus.user | ~USER_ONLY) & ~nmi;

    for (genvar gi = 0; gi < NBP; gi++) begin : g_cmp
        bkpt_cmp u_cmp (
            .clk_25mhz (clk_25mhz),
            .reset     (reset),
            .addr_wr   (we & (bus.rs == 4'(gi))),
            .en_wr     (ctrl_wr),
            .wdat      (bus.di),
            .en_dat    (bus.di[gi]),
            .qual      (qual),
            .ab        (bus.ab),
            .addr      (bp_addr[gi]),
            .en        (bp_en[gi]),
            .hit       (hit[gi])
        );
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            step_en  <= 1'b0;
            step_cnt <= '0;
            stat_hit <= '0;
            bp_pend  <= 1'b0;
        end else begin
            if (ctrl_wr)                      step_en  <= bus.di[CTRL_STEP_EN];
            if (we && bus.rs == RS_STEP)      step_cnt <= bus.di[CW-1:0];
            stat_hit <= (clr ? '0 : stat_hit) | hit;
            if (|hit)     bp_pend <= 1'b1;
            else if (fs)  bp_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            stat_step <= 1'b0;
        end else begin
            if (clr) stat_step <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (lrex && step_en) begin
                        state <= ST_COUNT;
                        cnt   <= (step_cnt == '0) ? CW'(DELAY) : step_cnt;
                    end
                end
                ST_COUNT: begin
                    if (!step_en) begin
                        state <= ST_IDLE;
                    end else if (lrex) begin
                        cnt <= (step_cnt == '0) ? CW'(DELAY) : step_cnt;
                    end else if (fs) begin
                        if (cnt == CW'(1)) begin
                            state     <= ST_FIRE;
                            stat_step <= 1'b1;
                        end
                        if (cnt != '0) cnt <= cnt - CW'(1);
                    end
                end
                ST_FIRE: begin
                    if (fs) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign nmi     = bp_pend | (state == ST_FIRE);
    assign bus.nmi = nmi;

    always_comb begin
        bus.dout = '0;
        if (!bus.csn) begin
            for (int i = 0; i < NBP; i++) begin
                if (bus.rs == 4'(i)) bus.dout = bp_addr[i];
            end
            case (bus.rs)
                RS_CTRL: begin
                    bus.dout[NBP-1:0]    = bp_en;
                    bus.dout[CTRL_STEP_EN] = step_en;
                end
                RS_STEP: bus.dout = 16'(step_cnt);
                RS_STAT: begin
                    bus.dout[NBP-1:0]   = stat_hit;
                    bus.dout[STAT_STEP] = stat_step;
                end
                default: ;
            endcase
        end
    end
endmodule
